player_sprite_renderer: RTL and testbench

Pixel-side consumer of the player position bus. Takes the 10-bit player x/y produced by the player control logic and the VGA scan counters, latches the position once per frame, and outputs per-pixel RGB with the player's 8×8 bitmap drawn at 4× scale over a flat background. Sits between the player control block and the VGA output pins. Delays hsync/vsync so that they stay aligned with the RGB outputs.

---
 rtl/player_sprite_renderer.sv | 159 +++++++++++++++
 tb/tb_player_sprite_renderer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/player_sprite_renderer.sv
// Two-stage pixel pipeline drawing an 8x8 player bitmap at 4x scale over a flat background.
// Optional SPRITE_FRAME_LATCH_EN: sample the player position once per frame instead of every cycle.
module player_sprite_renderer #(
    parameter int             H_DISPLAY     = 640,
    parameter int             V_DISPLAY     = 480,
    parameter int             PLAYER_WIDTH  = 32,
    parameter int             PLAYER_HEIGHT = 32,
    parameter logic [8:0]     BG_COLOR      = 9'b000_011_000,
    parameter logic [8:0]     PLAYER_COLOR  = 9'b111_111_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] h_count_i,
    input  logic [9:0] v_count_i,
    input  logic       display_en_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic [9:0] player_x_i,
    input  logic [9:0] player_y_i,
    output logic [2:0] vga_r_o,
    output logic [2:0] vga_g_o,
    output logic [2:0] vga_b_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       player_on_o,
    output logic       frame_tick_o
);

    localparam logic [9:0]  MAX_X = 10'(H_DISPLAY - PLAYER_WIDTH);
    localparam logic [9:0]  MAX_Y = 10'(V_DISPLAY - PLAYER_HEIGHT);
    localparam logic [10:0] SPR_W = 11'(PLAYER_WIDTH);
    localparam logic [10:0] SPR_H = 11'(PLAYER_HEIGHT);

    function automatic logic [7:0] sprite_row(input logic [2:0] r);
        case (r)
            3'd0:    sprite_row = 8'h3C;
            3'd1:    sprite_row = 8'h7E;
            3'd2:    sprite_row = 8'hDB;
            3'd3:    sprite_row = 8'hFF;
            3'd4:    sprite_row = 8'hFF;
            3'd5:    sprite_row = 8'h7E;
            3'd6:    sprite_row = 8'h66;
            default: sprite_row = 8'hC3;
        endcase
    endfunction

    logic [9:0] clamp_x, clamp_y, pos_x, pos_y;
    logic       latch_cond;

    assign clamp_x    = (player_x_i > MAX_X) ? MAX_X : player_x_i;
    assign clamp_y    = (player_y_i > MAX_Y) ? MAX_Y : player_y_i;
    assign latch_cond = (v_count_i == 10'(V_DISPLAY)) && (h_count_i == 10'd0);

`ifdef SPRITE_FRAME_LATCH_EN
    localparam logic [9:0] DEF_X = 10'(H_DISPLAY / 2 - PLAYER_WIDTH / 2);
    localparam logic [9:0] DEF_Y = 10'(V_DISPLAY - PLAYER_HEIGHT);

    logic [9:0] lat_x_q, lat_x_d, lat_y_q, lat_y_d;

    always_comb begin
        lat_x_d = lat_x_q;
        lat_y_d = lat_y_q;
        if (latch_cond) begin
            lat_x_d = clamp_x;
            lat_y_d = clamp_y;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lat_x_q <= DEF_X;
            lat_y_q <= DEF_Y;
        end else begin
            lat_x_q <= lat_x_d;
            lat_y_q <= lat_y_d;
        end
    end

    assign pos_x = lat_x_q;
    assign pos_y = lat_y_q;
`else
    assign pos_x = clamp_x;
    assign pos_y = clamp_y;
`endif

    // Stage 1: box test and bitmap coordinates
    logic       in_box_q, in_box_d;
    logic [2:0] col_q, col_d, row_q, row_d;
    logic       de1_q, hs1_q, vs1_q;
    logic [10:0] h11, v11, px11, py11;

    always_comb begin
        h11      = {1'b0, h_count_i};
        v11      = {1'b0, v_count_i};
        px11     = {1'b0, pos_x};
        py11     = {1'b0, pos_y};
        in_box_d = (h11 >= px11) && (h11 < px11 + SPR_W) &&
                   (v11 >= py11) && (v11 < py11 + SPR_H);
        // Only bits [4:2] of the offset matter: 32-pixel sprite, 4x scale
        col_d    = 3'((h_count_i[4:0] - pos_x[4:0]) >> 2);
        row_d    = 3'((v_count_i[4:0] - pos_y[4:0]) >> 2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_box_q <= 1'b0;
            col_q    <= 3'd0;
            row_q    <= 3'd0;
            de1_q    <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
        end else begin
            in_box_q <= in_box_d;
            col_q    <= col_d;
            row_q    <= row_d;
            de1_q    <= display_en_i;
            hs1_q    <= hsync_i;
            vs1_q    <= vsync_i;
        end
    end

    // Stage 2: bitmap lookup and colour select
    logic [7:0] row_bits;
    logic       lit;
    logic [8:0] rgb_q, rgb_d;
    logic       on_q, on_d, hs2_q, vs2_q, tick_q;

    always_comb begin
        row_bits = sprite_row(row_q);
        lit      = in_box_q && row_bits[3'd7 - col_q];
        on_d     = de1_q && lit;
        rgb_d    = 9'd0;
        if (de1_q)
            rgb_d = lit ? PLAYER_COLOR : BG_COLOR;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_q  <= 9'd0;
            on_q   <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            rgb_q  <= rgb_d;
            on_q   <= on_d;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            tick_q <= latch_cond;
        end
    end

    assign {vga_r_o, vga_g_o, vga_b_o} = rgb_q;
    assign player_on_o  = on_q;
    assign hsync_o      = hs2_q;
    assign vsync_o      = vs2_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Scoreboard bench for player_sprite_renderer: directed pixel vectors with hand-derived colours.
module tb_player_sprite_renderer;

    localparam logic [8:0] BG = 9'b000_011_000;
    localparam logic [8:0] PL = 9'b111_111_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] h = '0, v = '0, pxi = 10'd304, pyi = 10'd448;
    logic       de = 1'b0, hs = 1'b1, vs = 1'b1;
    logic [2:0] r, g, b;
    logic       hso, vso, pon, tick;

    player_sprite_renderer dut (
        .clk_i(clk), .rst_i(rst), .h_count_i(h), .v_count_i(v),
        .display_en_i(de), .hsync_i(hs), .vsync_i(vs),
        .player_x_i(pxi), .player_y_i(pyi),
        .vga_r_o(r), .vga_g_o(g), .vga_b_o(b),
        .hsync_o(hso), .vsync_o(vso), .player_on_o(pon), .frame_tick_o(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [8:0] rgb;
        logic       on, hs, vs;
        int         id;
    } pix_t;
    typedef struct {
        int   due;
        logic t;
        int   id;
    } tick_t;

    pix_t  pq[$];
    tick_t tq[$];
    int cyc = 0, vectors = 0, errors = 0, vid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare everything due at this cycle
    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            pix_t e;
            e = pq.pop_front();
            if (e.due == cyc) begin
                vectors++;
                if ({r, g, b} !== e.rgb || pon !== e.on || hso !== e.hs || vso !== e.vs) begin
                    errors++;
                    $display("FAIL pix#%0d: got rgb=%b on=%b hs=%b vs=%b, want rgb=%b on=%b hs=%b vs=%b",
                             e.id, {r, g, b}, pon, hso, vso, e.rgb, e.on, e.hs, e.vs);
                end
            end
        end
        while (tq.size() > 0 && tq[0].due <= cyc) begin
            tick_t t;
            t = tq.pop_front();
            if (t.due == cyc) begin
                vectors++;
                if (tick !== t.t) begin
                    errors++;
                    $display("FAIL tick#%0d: got frame_tick=%b, want %b", t.id, tick, t.t);
                end
            end
        end
    end

    // code: 0 = black, 1 = background, 2 = sprite
    task automatic px(input int hh, input int vv, input bit dd, input bit hh_s, input bit vv_s,
                      input int code);
        pix_t  e;
        tick_t t;
        @(negedge clk);
        rst = 1'b0;
        h = 10'(hh); v = 10'(vv); de = dd; hs = hh_s; vs = vv_s;
        vid++;
        e.due = cyc + 2;
        e.rgb = (code == 2) ? PL : (code == 1) ? BG : 9'd0;
        e.on  = (code == 2);
        e.hs  = hh_s;
        e.vs  = vv_s;
        e.id  = vid;
        pq.push_back(e);
        t.due = cyc + 1;
        t.t   = (vv == 480 && hh == 0);
        t.id  = vid;
        tq.push_back(t);
    endtask

    task automatic reset_cycles(input int n, input int hh, input int vv);
        for (int i = 0; i < n; i++) begin
            pix_t  e;
            tick_t t;
            @(negedge clk);
            rst = 1'b1;
            h = 10'(hh); v = 10'(vv); de = 1'b1; hs = 1'b0; vs = 1'b0;
            while (pq.size() > 0 && pq[$].due >= cyc + 1) void'(pq.pop_back());
            while (tq.size() > 0 && tq[$].due >= cyc + 1) void'(tq.pop_back());
            vid++;
            e.due = cyc + 1; e.rgb = 9'd0; e.on = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.id = vid;
            pq.push_back(e);
            t.due = cyc + 1; t.t = 1'b0; t.id = vid;
            tq.push_back(t);
        end
    endtask

    initial begin
        reset_cycles(3, 100, 100);
        // Default position (304,448)
        px(304, 448, 1, 1, 1, 1);   // row 0 = 3C, col 0 dark
        px(312, 448, 1, 1, 1, 2);   // col 2 lit
        px(303, 448, 1, 1, 1, 1);   // left of box
        px(335, 479, 1, 1, 1, 2);   // row 7 = C3, col 7
        px(336, 479, 1, 1, 1, 1);   // right of box
        px(304, 460, 1, 1, 1, 2);   // row 3 = FF
        px(316, 456, 1, 1, 1, 2);   // row 2 = DB, col 3 lit
        px(312, 456, 1, 1, 1, 1);   // row 2 = DB, col 2 dark
        // Latency / blanking / sync delay
        px(100, 100, 1, 1, 1, 1);
        px(100, 100, 0, 1, 1, 0);
        px(100, 100, 1, 0, 1, 1);
        px(100, 100, 1, 1, 0, 1);
        px(310, 450, 0, 0, 0, 0);   // sprite pixel but blanked
`ifdef SPRITE_FRAME_LATCH_EN
        pxi = 10'd0; pyi = 10'd0;
        px(312, 448, 1, 1, 1, 2);   // no effect before latch
        px(0, 12, 1, 1, 1, 1);
        px(0, 480, 0, 1, 0, 0);     // latch point
        px(0, 12, 1, 1, 1, 2);
        px(0, 0, 1, 1, 1, 1);
        px(312, 448, 1, 1, 1, 1);
        pxi = 10'd630; pyi = 10'd470;
        px(0, 480, 0, 1, 0, 0);     // latches clamped 608,448
        px(639, 479, 1, 1, 1, 2);
        px(607, 479, 1, 1, 1, 1);
        px(608, 448, 1, 1, 1, 1);
        pxi = 10'd64; pyi = 10'd64;
        px(0, 480, 0, 1, 0, 0);
        px(64, 76, 1, 1, 1, 2);
        px(100, 240, 1, 1, 1, 1);
        reset_cycles(1, 0, 480);    // reset beats coincident latch
        px(304, 460, 1, 1, 1, 2);
        px(64, 76, 1, 1, 1, 1);
`else
        pxi = 10'd0;
        px(0, 460, 1, 1, 1, 2);     // moves within same frame
        px(304, 460, 1, 1, 1, 1);
        pxi = 10'd630; pyi = 10'd470;
        px(639, 479, 1, 1, 1, 2);
        px(607, 479, 1, 1, 1, 1);
        px(608, 448, 1, 1, 1, 1);
        px(0, 480, 0, 1, 0, 0);     // tick still generated
        px(1, 480, 0, 1, 0, 0);
        pxi = 10'd64; pyi = 10'd64;
        px(64, 76, 1, 1, 1, 2);
        reset_cycles(1, 0, 480);
        px(64, 76, 1, 1, 1, 2);
        px(304, 460, 1, 1, 1, 1);
`endif
        repeat (4) @(negedge clk);
        #1;
        if (pq.size() != 0 || tq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", pq.size() + tq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
